// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Lookup is combinational from registered state; resolved branches train the table.
module branch_predictor_btb #(
  parameter int ENTRIES    = 16,
  parameter int ADDR_WIDTH = 64,
  parameter int CNT_BITS   = 2,
  parameter int MODE       = 1,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_hit,
  output logic                  predict_taken,
  output logic [ADDR_WIDTH-1:0] predict_target,
  input  logic                  update_valid,
  input  logic [ADDR_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [ADDR_WIDTH-1:0] update_target,
  input  logic                  update_pred_taken,
  input  logic [ADDR_WIDTH-1:0] update_pred_target,
  input  logic                  flush,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam bit DYN   = (MODE == 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

  logic [ENTRIES-1:0]    valid;
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [CNT_BITS-1:0]   cnt_q    [ENTRIES];

  logic [IDX-1:0]   lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, alloc, mispredicted;

  assign lk_idx  = lookup_pc[IDX+1:2];
  assign lk_tag  = lookup_pc[ADDR_WIDTH-1:IDX+2];
  assign upd_idx = update_pc[IDX+1:2];
  assign upd_tag = update_pc[ADDR_WIDTH-1:IDX+2];

  assign lookup_hit     = valid[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign predict_taken  = DYN && lookup_hit && cnt_q[lk_idx][CNT_BITS-1];
  assign predict_target = predict_taken ? target_q[lk_idx]
                                        : lookup_pc + ADDR_WIDTH'(4);

  assign upd_hit = valid[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // flush suppresses allocation so no entry survives the invalidate
  assign alloc   = update_valid && update_taken && !upd_hit && !flush;

  assign mispredicted = (update_taken != update_pred_taken) ||
                        (update_taken && update_pred_taken &&
                         (update_target != update_pred_target));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid            <= '0;
      mispredict       <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= '0;
    end else begin
      if (flush)      valid          <= '0;
      else if (alloc) valid[upd_idx] <= 1'b1;

      if (update_valid) begin
        if (upd_hit) begin
          if (update_taken)
            cnt_q[upd_idx] <= (cnt_q[upd_idx] == CNT_MAX) ? CNT_MAX
                                                         : cnt_q[upd_idx] + CNT_BITS'(1);
          else
            cnt_q[upd_idx] <= (cnt_q[upd_idx] == '0) ? '0
                                                    : cnt_q[upd_idx] - CNT_BITS'(1);
        end else if (alloc) begin
          cnt_q[upd_idx] <= CNT_WEAK;
        end
      end

      mispredict <= update_valid && mispredicted;

      if (update_valid && (stat_branches != '1))
        stat_branches <= stat_branches + STAT_WIDTH'(1);
      if (update_valid && mispredicted && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_WIDTH'(1);
    end
  end

  // Tags and targets are only meaningful under a valid bit, so they carry no reset
  always_ff @(posedge clock) begin
    if (update_valid && update_taken && (upd_hit || alloc))
      target_q[upd_idx] <= update_target;
    if (alloc)
      tag_q[upd_idx] <= upd_tag;
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: a dynamic-mode instance and a static-mode
// instance with narrow statistics share all inputs.
module tb_branch_predictor_btb;

  logic        clock, reset;
  logic [63:0] lookup_pc;
  logic        update_valid, update_taken, update_pred_taken, flush;
  logic [63:0] update_pc, update_target, update_pred_target;

  logic        hit, ptk, misp;
  logic [63:0] ptgt;
  logic [31:0] st_br, st_mis;

  logic        s_hit, s_ptk, s_misp;
  logic [63:0] s_ptgt;
  logic [3:0]  s_br, s_mis;

  int checks = 0;
  int errors = 0;

  branch_predictor_btb #(.ENTRIES(16), .ADDR_WIDTH(64), .CNT_BITS(2), .MODE(1), .STAT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .lookup_hit(hit), .predict_taken(ptk), .predict_target(ptgt),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .flush(flush),
    .mispredict(misp), .stat_branches(st_br), .stat_mispredicts(st_mis)
  );

  branch_predictor_btb #(.ENTRIES(16), .ADDR_WIDTH(64), .CNT_BITS(2), .MODE(0), .STAT_WIDTH(4)) dut_s (
    .clock(clock), .reset(reset), .lookup_pc(lookup_pc),
    .lookup_hit(s_hit), .predict_taken(s_ptk), .predict_target(s_ptgt),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target), .flush(flush),
    .mispredict(s_misp), .stat_branches(s_br), .stat_mispredicts(s_mis)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic look(input logic [63:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  task automatic do_update(input logic [63:0] pc, input logic tk, input logic [63:0] tg,
                           input logic ptk_i, input logic [63:0] ptg);
    update_valid       = 1'b1;
    update_pc          = pc;
    update_taken       = tk;
    update_target      = tg;
    update_pred_taken  = ptk_i;
    update_pred_target = ptg;
    tick();
    update_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; lookup_pc = 64'h4; flush = 1'b0;
    update_valid = 1'b0; update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_pred_taken = 1'b0; update_pred_target = '0;
    #2 reset = 1'b0;
    #1;
    // reset state
    check_val("rst_hit",   hit,    0);
    check_val("rst_ptk",   ptk,    0);
    check_val("rst_tgt",   ptgt,   64'h8);
    check_val("rst_br",    st_br,  0);
    check_val("rst_mis",   st_mis, 0);
    check_val("rst_misp",  misp,   0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;

    // first allocation, mispredicted
    do_update(64'h0C, 1, 64'h1C, 0, 64'h0);
    look(64'h0C);
    check_val("alloc_misp", misp,   1);
    check_val("alloc_br",   st_br,  1);
    check_val("alloc_mis",  st_mis, 1);
    check_val("alloc_hit",  hit,    1);
    check_val("alloc_ptk",  ptk,    1);
    check_val("alloc_tgt",  ptgt,   64'h1C);
    check_val("s_alloc_hit", s_hit, 1);
    check_val("s_alloc_ptk", s_ptk, 0);
    check_val("s_alloc_tgt", s_ptgt, 64'h10);
    tick();
    check_val("misp_pulse", misp, 0);

    // counter training: 2 -> 3 (sat) -> 2 -> 1
    repeat (3) do_update(64'h0C, 1, 64'h1C, 1, 64'h1C);
    check_val("sat_misp", misp, 0);
    check_val("sat_ptk",  ptk,  1);
    do_update(64'h0C, 0, 64'h0, 1, 64'h1C);
    check_val("nt1_misp", misp, 1);
    check_val("nt1_ptk",  ptk,  1);
    check_val("nt1_tgt",  ptgt, 64'h1C);
    do_update(64'h0C, 0, 64'h0, 1, 64'h1C);
    check_val("nt2_hit",  hit,  1);
    check_val("nt2_ptk",  ptk,  0);
    check_val("nt2_tgt",  ptgt, 64'h10);
    check_val("nt2_br",   st_br,  6);
    check_val("nt2_mis",  st_mis, 3);

    // aliasing: 0x4C replaces 0x0C at index 3
    do_update(64'h4C, 1, 64'h5C, 0, 64'h0);
    look(64'h0C);
    check_val("alias_old_hit", hit, 0);
    look(64'h4C);
    check_val("alias_new_hit", hit,  1);
    check_val("alias_new_ptk", ptk,  1);
    check_val("alias_new_tgt", ptgt, 64'h5C);
    check_val("alias_mis",     st_mis, 4);

    // same-cycle lookup/update: no bypass
    lookup_pc          = 64'h20;
    update_valid       = 1'b1;
    update_pc          = 64'h20;
    update_taken       = 1'b1;
    update_target      = 64'h30;
    update_pred_taken  = 1'b1;
    update_pred_target = 64'h30;
    #1;
    check_val("same_pre_hit", hit, 0);
    tick();
    update_valid = 1'b0;
    check_val("same_post_hit", hit,  1);
    check_val("same_post_tgt", ptgt, 64'h30);
    check_val("same_misp",     misp, 0);

    // flush wins over allocation; stats still count
    flush = 1'b1;
    do_update(64'h24, 1, 64'h40, 1, 64'h40);
    flush = 1'b0;
    look(64'h24);
    check_val("flush_new_hit", hit, 0);
    look(64'h20);
    check_val("flush_old_hit", hit, 0);
    check_val("flush_br",      st_br, 9);

    // statistics saturation on the 4-bit instance
    repeat (8) do_update(64'h100, 0, 64'h0, 0, 64'h0);
    check_val("br_wide",  st_br, 17);
    check_val("br_sat",   s_br,  15);
    check_val("mis_narrow", s_mis, 4);

    // static mode after reset, then reset mid-sequence
    @(posedge clock); #1 reset = 1'b0;
    #1 reset = 1'b1;
    do_update(64'h0C, 1, 64'h1C, 0, 64'h0);
    do_update(64'h0C, 1, 64'h1C, 0, 64'h0);
    look(64'h0C);
    check_val("s_hit",  s_hit,  1);
    check_val("s_ptk",  s_ptk,  0);
    check_val("s_tgt",  s_ptgt, 64'h10);
    check_val("s_misp", s_misp, 1);
    check_val("s_br2",  s_br,   2);
    check_val("d_ptk",  ptk,    1);
    update_valid      = 1'b1;
    update_pc         = 64'h0C;
    update_taken      = 1'b1;
    update_pred_taken = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_val("mid_s_hit",  s_hit,  0);
    check_val("mid_s_ptk",  s_ptk,  0);
    check_val("mid_s_tgt",  s_ptgt, 64'h10);
    check_val("mid_s_br",   s_br,   0);
    check_val("mid_s_mis",  s_mis,  0);
    check_val("mid_s_misp", s_misp, 0);
    check_val("mid_d_hit",  hit,    0);
    check_val("mid_d_br",   st_br,  0);
    tick();
    check_val("held_d_br",  st_br, 0);
    reset = 1'b1;
    tick();
    update_valid = 1'b0;
    check_val("first_upd_br",  st_br, 1);
    check_val("first_upd_hit", hit,   1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised direct-mapped branch target buffer with saturating-counter direction prediction for the fetch stage of the pipelined ARMv8 core.
- Fetch presents the current PC and receives a same-cycle hit, a taken/not-taken prediction and a target.
- When a conditional branch (CBZ/CBNZ/B.cond) resolves, execute sends an update. The block trains its state, flags mispredictions one cycle later, and keeps resolved-branch and mispredict statistics.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, >= 2
ADDR_WIDTH, 64, PC/target width
CNT_BITS, 2, saturating counter width per entry, 1..4
MODE, 1, 0 = static not-taken (tables never consulted); 1 = dynamic counter prediction
STAT_WIDTH, 32, width of statistics counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
lookup_pc  in  ADDR_WIDTH  fetch PC
lookup_hit  out  1  valid entry with matching tag
predict_taken  out  1  predicted direction
predict_target  out  ADDR_WIDTH  predicted target; lookup_pc+4 when not predicting taken
update_valid  in  1  resolved branch present this cycle
update_pc  in  ADDR_WIDTH  PC of resolved branch
update_taken  in  1  actual direction
update_target  in  ADDR_WIDTH  actual taken target
update_pred_taken  in  1  direction that was predicted for this branch
update_pred_target  in  ADDR_WIDTH  target that was predicted for this branch
flush  in  1  synchronous invalidate of all entries
mispredict  out  1  registered pulse: the previous cycle's update was mispredicted
stat_branches  out  STAT_WIDTH  resolved branches counted
stat_mispredicts  out  STAT_WIDTH  mispredictions counted

Behaviour:
Indexing and lookup:
- IDX = log2(ENTRIES).
- index = pc[IDX+1:2]; tag = pc[ADDR_WIDTH-1:IDX+2]; pc[1:0] ignored.
- Each entry holds: valid, tag, target, counter.
- Lookup is combinational from registered state (zero latency).
- lookup_hit = valid & tag match.
- predict_taken = (MODE==1) & hit & counter MSB.
- predict_target = entry target if predict_taken, else lookup_pc+4 (modulo 2^ADDR_WIDTH).
- MODE 0: lookup_hit still reports, predict_taken=0, table updates still occur.

Update (rising edge, update_valid=1):
- Hit, taken: counter saturating +1 (max 2^CNT_BITS-1); target <= update_target.
- Hit, not-taken: counter saturating -1 (min 0); target unchanged.
- Miss, taken: allocate/replace the entry: valid=1, tag, target, counter = weakly taken (MSB=1, other bits 0, e.g. 2'b10).
- Miss, not-taken: no change.

Misprediction and statistics:
- Mispredicted = update_taken != update_pred_taken, OR (update_taken & update_pred_taken & update_target != update_pred_target).
- mispredict <= update_valid & mispredicted; otherwise 0 (one-cycle pulse per update).
- stat_branches += 1 per update_valid.
- stat_mispredicts += 1 per mispredicted update.
- Both saturate at all-ones; no wrap.

Simultaneous events:
- Lookup and update to the same index in the same cycle: lookup sees pre-update state (no bypass).
- flush and update_valid in the same cycle: flush wins; all valid bits cleared, no allocation. Counters/statistics/mispredict still update normally.
- flush clears only valid bits; targets and counters keep stale values, which become irrelevant.

Reset:
- reset=0 asynchronously clears all valid bits, counters (to 0), mispredict and both statistics. Outputs are then lookup_hit=0, predict_taken=0, predict_target=lookup_pc+4.
- Reset asserted mid-operation discards any in-flight update.
- Deassertion is synchronous to clock; first update is accepted on the first edge with reset=1.

Test Plan:
1. Reset then lookup_pc=0x04 -> hit=0, predict_taken=0, predict_target=0x08; stats=0, mispredict=0.
2. Update pc=0x0C taken target=0x1C pred_taken=0 -> next cycle mispredict=1, stat_branches=1, stat_mispredicts=1. Lookup 0x0C -> hit=1, predict_taken=1, target=0x1C (counter=2).
3. Train pc=0x0C: three taken updates (counter saturates at 3), then two not-taken -> prediction stays taken after first not-taken (counter 2), flips to not-taken after second (counter 1). Target stays 0x1C.
4. Aliasing, ENTRIES=16: taken update at 0x0C then taken at 0x4C (same index, different tag) -> lookup 0x0C hit=0; lookup 0x4C hit=1, target from the second update.
5. Same cycle: update 0x20 taken, lookup 0x20 -> hit=0 this cycle, hit=1 next. Repeat with flush=1 -> hit=0 next cycle, stat_branches still increments.
6. MODE=0 build: after taken-training of 0x0C, lookup -> hit=1, predict_taken=0, target=0x10. Taken update with pred_taken=0 -> mispredict=1. Assert reset mid-sequence -> all outputs and stats cleared immediately.
